evr_v2_time_stamp_generator: RTL and testbench
==============================================

EVR_V2_TIME_STAMP_GENERATOR -- requirements
Module: evr_v2_time_stamp_generator

Interface
REQ-001 Parameter TICKS_PER_SEC, default 330556: Clock cycles per second, legal range 2 .. 2^FRAC_WIDTH.
REQ-002 Parameter SEC_WIDTH, default 32: width of the seconds field.
REQ-003 Parameter FRAC_WIDTH, default 32: width of the sub-second tick field.
REQ-004 Parameter NUM_LATCH, default 4: number of independent capture channels, 1..16.
REQ-005 Clock  input  1  sole clock; every register is updated on its rising edge.
REQ-006 Reset  input  1  asynchronous, active-high; clears all state while high.
REQ-007 SyncMode  input  1  0 = free-run; 1 = PPS-disciplined.
REQ-008 PpsIn  input  1  one-cycle pulse, already synchronous to Clock; marks a second boundary.
REQ-009 SecLoadValid  input  1  one-cycle strobe that qualifies SecLoadValue.
REQ-010 SecLoadValue  input  SEC_WIDTH  seconds value to apply at the next boundary.
REQ-011 ErrClear  input  1  clears PpsErr.
REQ-012 Latch  input  NUM_LATCH  per-channel capture strobe, level-sampled each cycle.
REQ-013 TimeStamp  output  SEC_WIDTH+FRAC_WIDTH  {Seconds, Frac}, registered.
REQ-014 SecPending  output  1  a loaded seconds value is waiting for a boundary.
REQ-015 PpsErr  output  1  sticky flag: PPS arrived off its expected boundary.
REQ-016 LatchStamp  output  NUM_LATCH*(SEC_WIDTH+FRAC_WIDTH)  captured stamps; channel i occupies slice i.
REQ-017 LatchValid  output  NUM_LATCH  one-cycle pulse per channel when its stamp is updated.

Function
REQ-018 Frac counts 0..TICKS_PER_SEC-1 and increments by 1 every cycle.
REQ-019 Boundary event: Frac == TICKS_PER_SEC-1 (both modes), or PpsIn == 1 while SyncMode == 1.
REQ-020 On a boundary event, Frac <= 0 on the next edge.
REQ-021 On a boundary event with a pending value: Seconds <= pending value and SecPending clears.
REQ-022 On a boundary event with no pending value: Seconds <= Seconds+1, wrapping modulo 2^SEC_WIDTH.
REQ-023 With SyncMode == 0, PpsIn is ignored entirely.
REQ-024 SecLoadValid stores SecLoadValue in the pending register and sets SecPending; a later load before the boundary overwrites it (last wins).
REQ-025 SecLoadValid in the same cycle as a boundary event:
  - the boundary consumes the old pending value, or increments if none;
  - the new value becomes pending and SecPending stays/goes 1.
REQ-026 PpsErr sets when PpsIn == 1, SyncMode == 1 and Frac != TICKS_PER_SEC-1; the realignment still occurs.
REQ-027 PpsErr clears only on ErrClear or Reset; a set condition coincident with ErrClear leaves PpsErr = 1.
REQ-028 A PPS coincident with natural rollover (Frac == TICKS_PER_SEC-1) is one boundary: Seconds advances once and PpsErr is not set.
REQ-029 TimeStamp <= {Seconds, Frac} of the current state each cycle (1-cycle latency), so TimeStamp is monotonic except at a pending-value load.
REQ-030 For each channel i with Latch[i] == 1: LatchStamp slice i <= TimeStamp (registered value) and LatchValid[i] = 1 for that cycle.
REQ-031 Channels with Latch[i] == 0 hold their slice, and LatchValid[i] = 0.
REQ-032 A Latch[i] held high captures every cycle.

Reset
REQ-033 While Reset is high, all of the following are 0: Frac, Seconds, pending register, SecPending, PpsErr, TimeStamp, LatchStamp, LatchValid.
REQ-034 After Reset deasserts, the first edge gives Frac = 1 and TimeStamp = 0; reset mid-second discards any pending value.

Verification (TICKS_PER_SEC=10, SEC_WIDTH=FRAC_WIDTH=8, NUM_LATCH=2)
REQ-035 Free-run, 25 cycles after reset -> TimeStamp steps 0x0000..0x0009, 0x0100..0x0109, 0x0200...; PpsErr = 0.
REQ-036 SecLoadValid with 0x50 at Frac = 3 -> SecPending = 1 until rollover, then Seconds = 0x50, SecPending = 0, next second 0x51.
REQ-037 SyncMode = 1, PpsIn at Frac = 4 -> Frac = 0, Seconds+1, PpsErr = 1; ErrClear -> PpsErr = 0; PpsIn at Frac = 9 -> single increment, PpsErr stays 0.
REQ-038 Seconds = 0xFF at rollover with no load -> Seconds = 0x00; load 0x10 in the rollover cycle -> wrap to 0x00, then 0x10 at the following boundary.
REQ-039 Latch = 2'b11 one cycle at TimeStamp = 0x0306 -> both slices = 0x0306 and LatchValid = 2'b11 for one cycle; a later Latch[0] updates slice 0 only.
REQ-040 Reset asserted asynchronously mid-second with SecPending = 1 and PpsErr = 1 -> all outputs 0 immediately, without waiting for a Clock edge.

Source files
------------

// File: rtl/evr_v2_time_stamp_generator.sv
// Seconds/sub-second time-of-day counter with optional PPS discipline,
// deferred seconds load, sticky PPS alignment error and per-channel stamp capture.
module evr_v2_time_stamp_generator #(
  parameter longint unsigned TICKS_PER_SEC = 330556,
  parameter int unsigned     SEC_WIDTH     = 32,
  parameter int unsigned     FRAC_WIDTH    = 32,
  parameter int unsigned     NUM_LATCH     = 4
) (
  input  logic                                          Clock,
  input  logic                                          Reset,
  input  logic                                          SyncMode,
  input  logic                                          PpsIn,
  input  logic                                          SecLoadValid,
  input  logic [SEC_WIDTH-1:0]                          SecLoadValue,
  input  logic                                          ErrClear,
  input  logic [NUM_LATCH-1:0]                          Latch,
  output logic [SEC_WIDTH+FRAC_WIDTH-1:0]               TimeStamp,
  output logic                                          SecPending,
  output logic                                          PpsErr,
  output logic [NUM_LATCH*(SEC_WIDTH+FRAC_WIDTH)-1:0]   LatchStamp,
  output logic [NUM_LATCH-1:0]                          LatchValid
);

  localparam int unsigned             TS_W     = SEC_WIDTH + FRAC_WIDTH;
  localparam logic [FRAC_WIDTH-1:0]   FRAC_MAX = FRAC_WIDTH'(TICKS_PER_SEC - 1);

  logic [FRAC_WIDTH-1:0]        r_frac_p0;
  logic [SEC_WIDTH-1:0]         r_sec_p0;
  logic [SEC_WIDTH-1:0]         r_pend_val_p0;
  logic                         r_pend_p0;
  logic                         r_pps_err_p0;
  logic [TS_W-1:0]              r_ts_p1;
  logic [NUM_LATCH*TS_W-1:0]    r_latch_stamp_p2;
  logic [NUM_LATCH-1:0]         r_latch_vld_p2;

  logic w_pps;
  logic w_at_max;
  logic w_boundary;
  logic w_pps_off;

  function automatic logic [SEC_WIDTH-1:0] next_sec(input logic                 pend,
                                                    input logic [SEC_WIDTH-1:0] pend_val,
                                                    input logic [SEC_WIDTH-1:0] sec);
    next_sec = pend ? pend_val : sec + SEC_WIDTH'(1);
  endfunction

  assign w_pps      = SyncMode & PpsIn;
  assign w_at_max   = (r_frac_p0 == FRAC_MAX);
  assign w_boundary = w_at_max | w_pps;
  // A PPS landing exactly on the natural rollover is the same boundary, not an error.
  assign w_pps_off  = w_pps & ~w_at_max;

  // Stage p0: time-of-day counter, pending seconds and PPS error flag
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_frac_p0     <= '0;
      r_sec_p0      <= '0;
      r_pend_val_p0 <= '0;
      r_pend_p0     <= 1'b0;
      r_pps_err_p0  <= 1'b0;
    end else begin
      if (w_boundary) begin
        r_frac_p0 <= '0;
        r_sec_p0  <= next_sec(r_pend_p0, r_pend_val_p0, r_sec_p0);
      end else begin
        r_frac_p0 <= r_frac_p0 + FRAC_WIDTH'(1);
      end
      // A load coincident with a boundary survives as the new pending value.
      if (SecLoadValid) begin
        r_pend_p0     <= 1'b1;
        r_pend_val_p0 <= SecLoadValue;
      end else if (w_boundary) begin
        r_pend_p0 <= 1'b0;
      end
      if (w_pps_off) begin
        r_pps_err_p0 <= 1'b1;
      end else if (ErrClear) begin
        r_pps_err_p0 <= 1'b0;
      end
    end
  end

  // Stage p1: registered time stamp
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_ts_p1 <= '0;
    end else begin
      r_ts_p1 <= {r_sec_p0, r_frac_p0};
    end
  end

  // Stage p2: per-channel capture of the registered stamp
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_latch_stamp_p2 <= '0;
      r_latch_vld_p2   <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_LATCH); i++) begin
        if (Latch[i]) begin
          r_latch_stamp_p2[i*TS_W +: TS_W] <= r_ts_p1;
        end
      end
      r_latch_vld_p2 <= Latch;
    end
  end

  assign TimeStamp  = r_ts_p1;
  assign SecPending = r_pend_p0;
  assign PpsErr     = r_pps_err_p0;
  assign LatchStamp = r_latch_stamp_p2;
  assign LatchValid = r_latch_vld_p2;

endmodule

// File: tb/tb_evr_v2_time_stamp_generator.sv
// Scoreboard bench for evr_v2_time_stamp_generator (10 ticks/s, 8-bit fields, 2 channels).
module tb_evr_v2_time_stamp_generator;

  logic        clk = 1'b0;
  logic        Reset;
  logic        SyncMode, PpsIn, SecLoadValid, ErrClear;
  logic [7:0]  SecLoadValue;
  logic [1:0]  Latch;
  logic [15:0] TimeStamp;
  logic        SecPending, PpsErr;
  logic [31:0] LatchStamp;
  logic [1:0]  LatchValid;

  evr_v2_time_stamp_generator #(
    .TICKS_PER_SEC(10), .SEC_WIDTH(8), .FRAC_WIDTH(8), .NUM_LATCH(2)
  ) dut (
    .Clock(clk), .Reset(Reset), .SyncMode(SyncMode), .PpsIn(PpsIn),
    .SecLoadValid(SecLoadValid), .SecLoadValue(SecLoadValue), .ErrClear(ErrClear),
    .Latch(Latch), .TimeStamp(TimeStamp), .SecPending(SecPending), .PpsErr(PpsErr),
    .LatchStamp(LatchStamp), .LatchValid(LatchValid)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] ts; logic pend; logic err; } exp_t;
  typedef struct { logic [1:0] m; logic [15:0] s0; logic [15:0] s1; } lat_t;
  exp_t q[$];
  lat_t lq[$];

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] m_sec, m_frac, m_pval;
  logic       m_pend, m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: state outputs are presented every cycle after each issued step.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("TimeStamp", 32'(TimeStamp), 32'(e.ts));
      chk("SecPending", 32'(SecPending), 32'(e.pend));
      chk("PpsErr", 32'(PpsErr), 32'(e.err));
    end
  end

  // Monitor: every LatchValid pulse must match a queued capture.
  always @(negedge clk) begin
    if (LatchValid != 2'b00) begin
      if (lq.size() == 0) begin
        chk("unexpected LatchValid", 32'(LatchValid), 32'd0);
      end else begin
        lat_t l;
        l = lq.pop_front();
        chk("LatchValid", 32'(LatchValid), 32'(l.m));
        chk("LatchStamp", LatchStamp, {l.s1, l.s0});
      end
    end
  end

  task automatic step(input logic sync, input logic pps, input logic ldv, input logic [7:0] ldval,
                      input logic clr, input logic [1:0] lat,
                      input logic [15:0] ets, input logic epend, input logic eerr);
    SyncMode = sync; PpsIn = pps; SecLoadValid = ldv; SecLoadValue = ldval;
    ErrClear = clr; Latch = lat;
    @(posedge clk);
    q.push_back('{ts: ets, pend: epend, err: eerr});
    @(negedge clk);
  endtask

  task automatic setm(input logic [7:0] s, input logic [7:0] f, input logic p,
                      input logic [7:0] pv, input logic e);
    m_sec = s; m_frac = f; m_pend = p; m_pval = pv; m_err = e;
  endtask

  // Quiet cycles: seconds follow natural rollover of a 10-tick second.
  task automatic free(input int n, input logic sync);
    logic [15:0] ets;
    for (int k = 0; k < n; k++) begin
      ets = {m_sec, m_frac};
      if (m_frac == 8'd9) begin
        m_sec  = m_pend ? m_pval : m_sec + 8'd1;
        m_pend = 1'b0;
        m_frac = 8'd0;
      end else begin
        m_frac = m_frac + 8'd1;
      end
      step(sync, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, ets, m_pend, m_err);
    end
  endtask

  task automatic exp_latch(input logic [1:0] m, input logic [15:0] s0, input logic [15:0] s1);
    lq.push_back('{m: m, s0: s0, s1: s1});
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " TimeStamp"}, 32'(TimeStamp), 32'd0);
    chk({tag, " SecPending"}, 32'(SecPending), 32'd0);
    chk({tag, " PpsErr"}, 32'(PpsErr), 32'd0);
    chk({tag, " LatchStamp"}, LatchStamp, 32'd0);
    chk({tag, " LatchValid"}, 32'(LatchValid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; SyncMode = 0; PpsIn = 0; SecLoadValid = 0; SecLoadValue = 0;
    ErrClear = 0; Latch = 0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    Reset = 1'b0;
    setm(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

    // Free run 0x0000..0x0009, 0x0100.., 0x0200..
    free(25, 1'b0);
    free(8, 1'b0);
    // Load 0x50 at frac 3
    step(0, 0, 1, 8'h50, 0, 2'b00, 16'h0303, 1'b1, 1'b0);
    setm(8'h03, 8'h04, 1'b1, 8'h50, 1'b0);
    free(3, 1'b0);
    // Capture both channels while TimeStamp shows 0x0306
    exp_latch(2'b11, 16'h0306, 16'h0306);
    step(0, 0, 0, 8'h00, 0, 2'b11, 16'h0307, 1'b1, 1'b0);
    setm(8'h03, 8'h08, 1'b1, 8'h50, 1'b0);
    free(2, 1'b0);
    free(10, 1'b0);
    exp_latch(2'b01, 16'h5009, 16'h0306);
    step(0, 0, 0, 8'h00, 0, 2'b01, 16'h5100, 1'b0, 1'b0);
    // Channel 1 held high; PPS ignored in free-run
    exp_latch(2'b10, 16'h5009, 16'h5100);
    step(0, 1, 0, 8'h00, 0, 2'b10, 16'h5101, 1'b0, 1'b0);
    exp_latch(2'b10, 16'h5009, 16'h5101);
    step(0, 0, 0, 8'h00, 0, 2'b10, 16'h5102, 1'b0, 1'b0);
    exp_latch(2'b10, 16'h5009, 16'h5102);
    step(0, 0, 0, 8'h00, 0, 2'b10, 16'h5103, 1'b0, 1'b0);

    // Early PPS at frac 4
    step(1, 1, 0, 8'h00, 0, 2'b00, 16'h5104, 1'b0, 1'b1);
    setm(8'h52, 8'h00, 1'b0, 8'h00, 1'b1);
    free(3, 1'b1);
    step(1, 0, 0, 8'h00, 1, 2'b00, 16'h5203, 1'b0, 1'b0);
    setm(8'h52, 8'h04, 1'b0, 8'h00, 1'b0);
    free(5, 1'b1);
    // PPS at frac 9: one boundary, no error
    step(1, 1, 0, 8'h00, 0, 2'b00, 16'h5209, 1'b0, 1'b0);
    setm(8'h53, 8'h00, 1'b0, 8'h00, 1'b0);
    free(1, 1'b1);
    // Error set wins over simultaneous clear
    step(1, 1, 0, 8'h00, 1, 2'b00, 16'h5301, 1'b0, 1'b1);
    step(0, 0, 0, 8'h00, 1, 2'b00, 16'h5400, 1'b0, 1'b0);

    // Seconds wrap 0xFF -> 0x00 with a load in the rollover cycle
    step(0, 0, 1, 8'hFF, 0, 2'b00, 16'h5401, 1'b1, 1'b0);
    setm(8'h54, 8'h02, 1'b1, 8'hFF, 1'b0);
    free(8, 1'b0);
    free(9, 1'b0);
    step(0, 0, 1, 8'h10, 0, 2'b00, 16'hFF09, 1'b1, 1'b0);
    setm(8'h00, 8'h00, 1'b1, 8'h10, 1'b0);
    free(10, 1'b0);
    free(1, 1'b0);
    // Last load wins; load at boundary consumes old pending value
    step(0, 0, 1, 8'h1F, 0, 2'b00, 16'h1001, 1'b1, 1'b0);
    step(0, 0, 1, 8'h20, 0, 2'b00, 16'h1002, 1'b1, 1'b0);
    setm(8'h10, 8'h03, 1'b1, 8'h20, 1'b0);
    free(6, 1'b0);
    step(0, 0, 1, 8'h30, 0, 2'b00, 16'h1009, 1'b1, 1'b0);
    setm(8'h20, 8'h00, 1'b1, 8'h30, 1'b0);
    free(10, 1'b0);
    free(1, 1'b0);

    // Pending + error, then asynchronous reset mid-cycle
    step(1, 1, 1, 8'h40, 0, 2'b00, 16'h3001, 1'b1, 1'b1);
    #2 Reset = 1'b1;
    #1 check_all_zero("async reset");
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    step(0, 0, 0, 8'h00, 0, 2'b00, 16'h0000, 1'b0, 1'b0);
    setm(8'h00, 8'h01, 1'b0, 8'h00, 1'b0);
    free(11, 1'b0);

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("state queue drained", 32'(q.size()), 32'd0);
    chk("latch queue drained", 32'(lq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
